// File: rtl/ct_spsram_param_shade_if.sv
// Bus bundle for ct_spsram_param_shade.
//   master : drives the access signals CEN, GWEN, A, D and WEN, plus their taint
//            companions, and observes Q, Q_t0 and BUSY.
//   slave  : the SRAM side of the bundle.
interface ct_spsram_param_shade_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 144
) ();
  logic                  CEN;
  logic                  GWEN;
  logic [ADDR_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] WEN;
  logic                  CEN_t0;
  logic                  GWEN_t0;
  logic [ADDR_WIDTH-1:0] A_t0;
  logic [DATA_WIDTH-1:0] D_t0;
  logic [DATA_WIDTH-1:0] WEN_t0;
  logic [DATA_WIDTH-1:0] Q;
  logic [DATA_WIDTH-1:0] Q_t0;
  logic                  BUSY;

  modport master (
    output CEN, GWEN, A, D, WEN, CEN_t0, GWEN_t0, A_t0, D_t0, WEN_t0,
    input  Q, Q_t0, BUSY
  );

  modport slave (
    input  CEN, GWEN, A, D, WEN, CEN_t0, GWEN_t0, A_t0, D_t0, WEN_t0,
    output Q, Q_t0, BUSY
  );
endinterface

// File: rtl/ct_spsram_param_shade.sv
// Single-port SRAM that carries a shadow taint array alongside the data array.
// After reset, an optional fill writes zeros to every row of both arrays.
//   CLK   : rising-edge clock for all state
//   RST_B : asynchronous reset, active-low
//   bus   : slave side of the access, taint and status signals
//           (CEN/GWEN/A/D/WEN in, their *_t0 taints in, Q/Q_t0/BUSY out)
//
// state  | meaning
// INIT   | zero-fill row cnt in both arrays each cycle, ignore accesses, BUSY=1
// READY  | normal reads and writes
module ct_spsram_param_shade #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 144,
  parameter bit OUT_REG    = 1'b0,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  ct_spsram_param_shade_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem    [DEPTH];
  logic [DATA_WIDTH-1:0] shadow [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rdt_q, rdt_d;
  logic [DATA_WIDTH-1:0] ctl_mask;
  logic                  ctl_t;
  logic                  ready;
  logic                  fill_we;
  logic                  wr_en;

  assign ctl_t    = bus.CEN_t0 | bus.GWEN_t0 | (|bus.A_t0);
  assign ctl_mask = {DATA_WIDTH{ctl_t}};
  assign ready    = (state_q == ST_READY);
  // The arrays have no reset; RST_B gates their write enables so that nothing
  // lands in them while reset is held (contents survive reset when INIT_EN=0).
  assign fill_we  = RST_B & (state_q == ST_INIT);
  assign wr_en    = RST_B & ready & ~bus.CEN & ~bus.GWEN;
  assign bus.BUSY = RST_B & (state_q == ST_INIT);

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q <= INIT_EN ? ST_INIT : ST_READY;
      cnt_q   <= '0;
      rd_q    <= '0;
      rdt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      rdt_q   <= rdt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (&cnt_q) state_d = ST_READY;
    end
  end

  // Read register. Writes leave it untouched, so there is no write-through.
  always_comb begin
    rd_d  = rd_q;
    rdt_d = rdt_q;
    if (!ready) begin
      rd_d  = '0;
      rdt_d = '0;
    end else if (bus.CEN) begin
      if (bus.CEN_t0) rdt_d = '1;
    end else if (bus.GWEN) begin
      rd_d  = mem[bus.A];
      rdt_d = shadow[bus.A] | ctl_mask;
    end
  end

  // Written bits take the data, write-enable and control taint. Masked bits
  // keep their old data and taint, but still pick up the taint of their
  // write-enable bit.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      mem[cnt_q]    <= '0;
      shadow[cnt_q] <= '0;
    end else if (wr_en) begin
      mem[bus.A]    <= (mem[bus.A] & bus.WEN) | (bus.D & ~bus.WEN);
      shadow[bus.A] <= bus.WEN_t0
                     | (~bus.WEN & (bus.D_t0 | ctl_mask))
                     | (bus.WEN & shadow[bus.A]);
    end
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic [DATA_WIDTH-1:0] q2_q, qt2_q;
      // The second stage loads every cycle, so hold behaviour reaches the
      // outputs one cycle later.
      always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
          q2_q  <= '0;
          qt2_q <= '0;
        end else begin
          q2_q  <= rd_q;
          qt2_q <= rdt_q;
        end
      end
      assign bus.Q    = q2_q;
      assign bus.Q_t0 = qt2_q;
    end else begin : g_noreg
      assign bus.Q    = rd_q;
      assign bus.Q_t0 = rdt_q;
    end
  endgenerate
endmodule

// File: tb/tb_ct_spsram_param_shade.sv
module tb_ct_spsram_param_shade;
  localparam int AW = 9;
  localparam int DW = 144;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] ZERO = '0;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  logic          cen, gwen, cen_t, gwen_t;
  logic [AW-1:0] a, a_t;
  logic [DW-1:0] d, d_t, wen, wen_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic busy2_seen = 1'b0;
  logic q_leak;

  // dut0: defaults; dut1: output register; dut2: no init fill
  ct_spsram_param_shade_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  ct_spsram_param_shade_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  ct_spsram_param_shade_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

  assign if0.CEN = cen;      assign if1.CEN = cen;      assign if2.CEN = cen;
  assign if0.GWEN = gwen;    assign if1.GWEN = gwen;    assign if2.GWEN = gwen;
  assign if0.A = a;          assign if1.A = a;          assign if2.A = a;
  assign if0.D = d;          assign if1.D = d;          assign if2.D = d;
  assign if0.WEN = wen;      assign if1.WEN = wen;      assign if2.WEN = wen;
  assign if0.CEN_t0 = cen_t; assign if1.CEN_t0 = cen_t; assign if2.CEN_t0 = cen_t;
  assign if0.GWEN_t0 = gwen_t; assign if1.GWEN_t0 = gwen_t; assign if2.GWEN_t0 = gwen_t;
  assign if0.A_t0 = a_t;     assign if1.A_t0 = a_t;     assign if2.A_t0 = a_t;
  assign if0.D_t0 = d_t;     assign if1.D_t0 = d_t;     assign if2.D_t0 = d_t;
  assign if0.WEN_t0 = wen_t; assign if1.WEN_t0 = wen_t; assign if2.WEN_t0 = wen_t;

  ct_spsram_param_shade #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1'b0), .INIT_EN(1'b1))
    dut0 (.CLK(clk), .RST_B(rst_b), .bus(if0));
  ct_spsram_param_shade #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1'b1), .INIT_EN(1'b1))
    dut1 (.CLK(clk), .RST_B(rst_b), .bus(if1));
  ct_spsram_param_shade #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1'b0), .INIT_EN(1'b0))
    dut2 (.CLK(clk), .RST_B(rst_b), .bus(if2));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (if2.BUSY) busy2_seen = 1'b1;
  endtask

  // Set up one access with all taints cleared.
  task automatic acc(input logic c, input logic g, input logic [AW-1:0] ad,
                     input logic [DW-1:0] dd, input logic [DW-1:0] ww);
    cen = c; gwen = g; a = ad; d = dd; wen = ww;
    cen_t = 1'b0; gwen_t = 1'b0; a_t = '0; d_t = '0; wen_t = '0;
  endtask

  task automatic idle();
    acc(1'b1, 1'b1, '0, '0, ONES);
  endtask

  // Count cycles until BUSY on dut0 drops, bounded.
  task automatic wait_fill(output int n);
    n = 0;
    while (if0.BUSY && n < 2000) begin
      cyc();
      n++;
    end
  endtask

  int n;

  initial begin
    idle();
    #2 rst_b = 1'b0;
    cyc(); cyc(); cyc();
    chk("rst_q0", if0.Q, ZERO);
    chk("rst_qt0", if0.Q_t0, ZERO);
    chk("rst_q1", if1.Q, ZERO);
    chk("rst_busy0", {143'b0, if0.BUSY}, ZERO);
    chk("rst_busy2", {143'b0, if2.BUSY}, ZERO);

    // first fill, with accesses driven throughout that must be ignored
    rst_b = 1'b1;
    #1;
    chk("rel_busy0", {143'b0, if0.BUSY}, {143'b0, 1'b1});
    chk("rel_busy2", {143'b0, if2.BUSY}, ZERO);
    q_leak = 1'b0;
    n = 0;
    while (if0.BUSY && n < 2000) begin
      if (n < 256) acc(1'b0, 1'b0, 9'd11, ONES, ZERO);
      else begin
        acc(1'b0, 1'b1, 9'd11, ZERO, ONES);
        a_t = 9'd1;
      end
      cyc();
      n++;
      if (if0.Q != ZERO || if0.Q_t0 != ZERO) q_leak = 1'b1;
    end
    idle();
    chk("fill_len", 144'(n), 144'(512));
    chk("fill_q_zero", {143'b0, q_leak}, ZERO);

    acc(1'b0, 1'b1, 9'd11, ZERO, ONES); cyc();
    chk("fill_ignore_q", if0.Q, ZERO);
    chk("fill_ignore_qt", if0.Q_t0, ZERO);
    acc(1'b0, 1'b1, 9'd0, ZERO, ONES); cyc();
    chk("init_r0_q", if0.Q, ZERO);
    acc(1'b0, 1'b1, 9'd511, ZERO, ONES); cyc();
    chk("init_r511_q", if0.Q, ZERO);
    chk("init_r511_qt", if0.Q_t0, ZERO);

    // full write then read, latency on both output variants
    acc(1'b0, 1'b0, 9'd5, ONES, ZERO); cyc();
    chk("no_wthru_q", if0.Q, ZERO);
    acc(1'b0, 1'b1, 9'd5, ZERO, ONES); cyc();
    chk("rd5_q0", if0.Q, ONES);
    chk("rd5_qt0", if0.Q_t0, ZERO);
    chk("rd5_q1_lat1", if1.Q, ZERO);
    idle(); cyc();
    chk("rd5_q1_lat2", if1.Q, ONES);
    chk("rd5_qt1_lat2", if1.Q_t0, ZERO);
    chk("rd5_q0_held", if0.Q, ONES);

    // single-bit write with data taint on that bit
    acc(1'b0, 1'b0, 9'd7, ONES, ~144'd1);
    d_t = 144'd1;
    cyc();
    acc(1'b0, 1'b1, 9'd7, ZERO, ONES); cyc();
    chk("rd7_q", if0.Q, 144'd1);
    chk("rd7_qt", if0.Q_t0, 144'd1);

    // fully masked write: data kept, WEN taint still recorded
    acc(1'b0, 1'b0, 9'd5, ZERO, ONES);
    wen_t = 144'd8;
    cyc();
    acc(1'b0, 1'b1, 9'd5, ZERO, ONES); cyc();
    chk("mask_q", if0.Q, ONES);
    chk("mask_qt", if0.Q_t0, 144'd8);

    // tainted address on read, then hold with and without CEN taint
    acc(1'b0, 1'b1, 9'd3, ZERO, ONES);
    a_t = 9'd1;
    cyc();
    chk("rd3_atnt_q", if0.Q, ZERO);
    chk("rd3_atnt_qt", if0.Q_t0, ONES);
    idle(); cyc();
    chk("hold_q", if0.Q, ZERO);
    chk("hold_qt", if0.Q_t0, ONES);
    acc(1'b0, 1'b1, 9'd5, ZERO, ONES); cyc();
    idle(); cyc();
    chk("hold5_q", if0.Q, ONES);
    chk("hold5_qt", if0.Q_t0, 144'd8);
    idle(); cen_t = 1'b1; cyc();
    chk("cen_tnt_q", if0.Q, ONES);
    chk("cen_tnt_qt", if0.Q_t0, ONES);

    // control-tainted write, read back-to-back
    acc(1'b0, 1'b0, 9'd20, 144'hABCD, ZERO);
    gwen_t = 1'b1;
    cyc();
    acc(1'b0, 1'b1, 9'd20, ZERO, ONES); cyc();
    chk("rd20_q", if0.Q, 144'hABCD);
    chk("rd20_qt", if0.Q_t0, ONES);
    acc(1'b0, 1'b0, 9'd30, 144'h1234, ZERO); cyc();
    acc(1'b0, 1'b1, 9'd30, ZERO, ONES); cyc();
    chk("b2b_q", if0.Q, 144'h1234);
    chk("b2b_qt", if0.Q_t0, ZERO);
    idle();

    // reset, abort fill at cycle 100, restart
    rst_b = 1'b0;
    cyc(); cyc();
    chk("rst2_q0", if0.Q, ZERO);
    chk("rst2_q1", if1.Q, ZERO);
    rst_b = 1'b1;
    #1;
    chk("rel2_busy0", {143'b0, if0.BUSY}, {143'b0, 1'b1});
    repeat (100) cyc();
    rst_b = 1'b0;
    #1;
    chk("abort_busy0", {143'b0, if0.BUSY}, ZERO);
    cyc(); cyc();
    rst_b = 1'b1;
    #1;
    wait_fill(n);
    chk("refill_len", 144'(n), 144'(512));

    acc(1'b0, 1'b1, 9'd5, ZERO, ONES); cyc();
    chk("refill_r5_q0", if0.Q, ZERO);
    chk("keep_r5_q2", if2.Q, ONES);
    chk("keep_r5_qt2", if2.Q_t0, 144'd8);
    acc(1'b0, 1'b1, 9'd30, ZERO, ONES); cyc();
    chk("keep_r30_q2", if2.Q, 144'h1234);
    idle(); cyc();
    chk("busy2_never", {143'b0, busy2_seen}, ZERO);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ct_spsram_param_shade.md
CT_SPSRAM_PARAM_SHADE -- requirements
Module: ct_spsram_param_shade

Interface
REQ-001 Parameter: ADDR_WIDTH, default 9, word address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 Parameter: DATA_WIDTH, default 144, data word width.
REQ-003 Parameter: OUT_REG, default 0; 0 gives 1-cycle read latency, 1 adds an output register for 2-cycle latency.
REQ-004 Parameter: INIT_EN, default 1; 1 zero-fills the data and shadow arrays after reset, 0 skips the fill.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Port: CLK, input, 1, rising-edge clock for all state.
REQ-007 Port: RST_B, input, 1, asynchronous active-low reset.
REQ-008 Port: CEN, input, 1, chip enable, active-low.
REQ-009 Port: GWEN, input, 1, global write enable, active-low (0 = write, 1 = read).
REQ-010 Port: A, input, ADDR_WIDTH, word address.
REQ-011 Port: D, input, DATA_WIDTH, write data.
REQ-012 Port: WEN, input, DATA_WIDTH, per-bit write enable, active-low.
REQ-013 Port: Q, output, DATA_WIDTH, read data.
REQ-014 Ports: CEN_t0, GWEN_t0 (1 bit); A_t0 (ADDR_WIDTH); D_t0, WEN_t0 (DATA_WIDTH); all inputs carrying the taint of the matching port.
REQ-015 Port: Q_t0, output, DATA_WIDTH, taint of Q.
REQ-016 Port: BUSY, output, 1, high while the init fill runs.

Function
REQ-017 The block SHALL hold a DEPTH x DATA_WIDTH data array and a same-shaped shadow (taint) array; neither array is reset.
REQ-018 FSM states SHALL be INIT and READY. On reset release, go to INIT if INIT_EN=1, else to READY. INIT -> READY the cycle after the fill counter writes row DEPTH-1.
REQ-019 In INIT, each cycle SHALL write all-zero data and all-zero taint to row cnt, then increment cnt (ADDR_WIDTH bits, starts at 0); BUSY=1. The fill SHALL take exactly DEPTH cycles.
REQ-020 In INIT, CEN/GWEN/A/D/WEN and their taints SHALL be ignored, and Q and Q_t0 SHALL stay 0.
REQ-021 Write, when READY with CEN=0 and GWEN=0: for every bit i with WEN[i]=0, mem[A][i] <= D[i] and shadow[A][i] <= D_t0[i] | WEN_t0[i] | ctl_t, where ctl_t = CEN_t0 | GWEN_t0 | (|A_t0).
REQ-022 Write: for bits with WEN[i]=1, data SHALL be unchanged, and shadow[A][i] <= shadow[A][i] | WEN_t0[i].
REQ-023 A write SHALL NOT change Q or Q_t0 (no write-through).
REQ-024 Read, when READY with CEN=0 and GWEN=1: the data path SHALL capture mem[A] into the read register at the edge.
REQ-025 Read: the taint path SHALL capture shadow[A] | {DATA_WIDTH{ctl_t}}.
REQ-026 Read latency: with OUT_REG=0, Q/Q_t0 are valid on the cycle after the request; with OUT_REG=1, they are valid 2 cycles after.
REQ-027 When CEN=1, Q and Q_t0 SHALL hold their last values. A tainted disabled cycle (CEN=1, CEN_t0=1) SHALL OR all ones into the held Q_t0.
REQ-028 With OUT_REG=1, the second stage SHALL load every cycle from the first stage, so hold behaviour carries through with one extra cycle of delay.
REQ-029 Back-to-back accesses SHALL be accepted every cycle; a read of the address written in the previous cycle SHALL return the new data and taint.
REQ-030 Address wrap: there is none; every A value addresses a unique row.

Reset
REQ-031 While RST_B=0: Q, Q_t0 and any OUT_REG stage SHALL be 0, cnt SHALL be 0, and BUSY SHALL be 0.
REQ-032 On reset release, BUSY SHALL equal INIT_EN.
REQ-033 Reset asserted mid-fill SHALL abort the fill; release restarts it at row 0 with the full DEPTH-cycle duration.
REQ-034 Array contents SHALL be preserved across reset when INIT_EN=0.

Verification
REQ-035 Defaults: release reset -> BUSY=1 for 512 cycles then 0; a read of any address -> Q=0 and Q_t0=0.
REQ-036 Write A=5, D=all-ones, WEN=0, taints 0; then read A=5 -> Q=all-ones and Q_t0=0 one cycle later (OUT_REG=0), two cycles later with OUT_REG=1.
REQ-037 Write A=7, D=all-ones, WEN=all-ones except bit 0, D_t0[0]=1; read A=7 -> Q=1, Q_t0=1.
REQ-038 Read A=3 with A_t0=1 -> Q_t0 = all-ones; next cycle CEN=1 with no taint -> Q and Q_t0 held unchanged.
REQ-039 Assert RST_B=0 at fill cycle 100, release -> BUSY stays high for a further 512 cycles; any access during the fill -> no array change and Q=0.
REQ-040 INIT_EN=0: write A=9, pulse reset, read A=9 -> original data returned; BUSY never asserts.
